sump_capture_core: RTL and testbench

Single-clock SUMP-protocol logic-analyzer core: decodes the host's command byte stream, samples a 32-bit input bus with a programmable divider, triggers on a masked-value match, stores samples in an internal buffer, and returns results byte by byte. It sits between the host transport (SPI or UART byte framer, outside this block) and the external probe pins. It is the capture engine of the Logic Sniffer top level.

---
 rtl/sump_capture_core.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_sump_capture_core.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sump_capture_core.sv
// sump_capture_core
// SUMP-protocol logic-analyzer capture engine. Decodes the host command byte
// stream, samples a 32-bit probe bus every (divider+1) clocks, triggers on a
// masked value match or the external trigger input, stores the trigger sample
// and the samples that follow it, then returns them byte by byte.
//
// Ports:
//   bf_clock       system clock (rising edge)
//   reset          synchronous active-high reset
//   rx_valid       strobe: rx_byte holds a host byte
//   rx_byte        host byte
//   tx_valid       strobe: tx_byte holds a response byte
//   tx_byte        response byte, held until the next tx_valid
//   dataReady      response bytes pending
//   extData        probe inputs
//   extTriggerIn   external trigger, level-sensitive while armed
//   extTriggerOut  one-cycle pulse when the trigger fires
//   armLEDnn       active-low armed indicator
//   triggerLEDnn   active-low triggered indicator
//
// Build option: define SUMP_TESTMODE_EN to let flags bit 11 replace the probe
// bus with a free-running counter.

module sump_capture_core #(
    parameter int unsigned MEM_DEPTH = 64,
    parameter logic [31:0] ID_WORD   = 32'h534C4131
) (
    input  logic        bf_clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    output logic        dataReady,
    input  logic [31:0] extData,
    input  logic        extTriggerIn,
    output logic        extTriggerOut,
    output logic        armLEDnn,
    output logic        triggerLEDnn
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StArmed, StCapture, StReadout} state_e;

    // (v+1)*4 samples, saturated at the buffer depth.
    function automatic logic [CW-1:0] clamp_count(input logic [15:0] v);
        logic [16:0] n;
        n = {1'b0, v} + 17'd1;
        if (n > 17'(MEM_DEPTH / 4)) begin
            return CW'(MEM_DEPTH);
        end
        return CW'({n, 2'b00});
    endfunction

    state_e        state_q;

    // Command decoder: cmd_cnt_q = 0 expects an opcode, 1..4 a data byte.
    logic [2:0]    cmd_cnt_q;
    logic [7:0]    opcode_q;
    logic [23:0]   cmd_data_q;
    logic [31:0]   cmd_word;

    // Configuration
    logic [23:0]   divider_q;
    logic [31:0]   rd_del_q;
    logic [3:0]    grp_dis_q;
    logic [31:0]   trig_mask_q;
    logic [31:0]   trig_value_q;
    logic          trig_en_q;
`ifdef SUMP_TESTMODE_EN
    logic          test_mode_q;
    logic [31:0]   test_cnt_q;
`endif

    // Capture datapath
    logic [23:0]   tick_cnt_q;
    logic [31:0]   ext_q;
    logic [31:0]   sample;
    logic          tick;
    logic          trig_hit;
    logic [CW-1:0] wr_ptr_q;
    logic          mem_we;
    logic [31:0]   mem [MEM_DEPTH];

    // Response queue: ID bytes first, then sample bytes during readout.
    logic [2:0]    id_left_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] rd_left_q;
    logic [1:0]    grp_q;
    logic [1:0]    grp_first;
    logic [1:0]    grp_next;
    logic          grp_any;
    logic          grp_more;
    logic          q_id;
    logic          q_smp;
    logic          pending;
    logic [1:0]    id_idx;
    logic [31:0]   rd_word;
    logic [7:0]    head_byte;
    logic [CW-1:0] read_n;
    logic [CW-1:0] delay_n;
    logic [CW-1:0] readout_len;

    // Registered outputs
    logic          tx_valid_q;
    logic [7:0]    tx_byte_q;
    logic          trig_out_q;
    logic          arm_led_q;
    logic          trig_led_q;

    always_comb begin
        grp_first = 2'd0;
        grp_any   = 1'b0;
        grp_next  = grp_q;
        grp_more  = 1'b0;
        // Walk downwards so the lowest qualifying group wins.
        for (int i = 3; i >= 0; i--) begin
            if (!grp_dis_q[i]) begin
                grp_first = 2'(i);
                grp_any   = 1'b1;
                if (2'(i) > grp_q) begin
                    grp_next = 2'(i);
                    grp_more = 1'b1;
                end
            end
        end
    end

    always_comb begin
`ifdef SUMP_TESTMODE_EN
        sample = test_mode_q ? test_cnt_q : ext_q;
`else
        sample = ext_q;
`endif
        tick     = (tick_cnt_q == 24'd0);
        trig_hit = extTriggerIn ||
                   (trig_en_q && ((sample & trig_mask_q) == (trig_value_q & trig_mask_q)));
        mem_we   = tick && (((state_q == StArmed) && trig_hit) || (state_q == StCapture));

        read_n      = clamp_count(rd_del_q[15:0]);
        delay_n     = clamp_count(rd_del_q[31:16]);
        readout_len = grp_any ? ((read_n < delay_n) ? read_n : delay_n) : '0;

        q_id      = (id_left_q != 3'd0);
        q_smp     = (state_q == StReadout) && (rd_left_q != '0) && grp_any;
        pending   = q_id || q_smp;
        id_idx    = 2'(3'd4 - id_left_q);
        rd_word   = mem[rd_ptr_q];
        head_byte = q_id ? ID_WORD[8*id_idx +: 8] : rd_word[8*grp_q +: 8];

        cmd_word  = {rx_byte, cmd_data_q};
    end

    always_ff @(posedge bf_clock) begin
        if (mem_we) begin
            mem[wr_ptr_q[AW-1:0]] <= sample;
        end
    end

    always_ff @(posedge bf_clock) begin
        if (reset) begin
            state_q      <= StIdle;
            cmd_cnt_q    <= 3'd0;
            opcode_q     <= 8'd0;
            cmd_data_q   <= 24'd0;
            divider_q    <= 24'd0;
            rd_del_q     <= 32'd0;
            grp_dis_q    <= 4'd0;
            trig_mask_q  <= 32'd0;
            trig_value_q <= 32'd0;
            trig_en_q    <= 1'b0;
`ifdef SUMP_TESTMODE_EN
            test_mode_q  <= 1'b0;
            test_cnt_q   <= 32'd0;
`endif
            tick_cnt_q   <= 24'd0;
            ext_q        <= 32'd0;
            wr_ptr_q     <= '0;
            id_left_q    <= 3'd0;
            rd_ptr_q     <= '0;
            rd_left_q    <= '0;
            grp_q        <= 2'd0;
            tx_valid_q   <= 1'b0;
            tx_byte_q    <= 8'd0;
            trig_out_q   <= 1'b0;
            arm_led_q    <= 1'b1;
            trig_led_q   <= 1'b1;
        end else begin
            tx_valid_q <= 1'b0;
            trig_out_q <= 1'b0;
            ext_q      <= extData;
`ifdef SUMP_TESTMODE_EN
            test_cnt_q <= test_cnt_q + 32'd1;
`endif

            if ((state_q == StArmed) || (state_q == StCapture)) begin
                tick_cnt_q <= tick ? divider_q : (tick_cnt_q - 24'd1);
            end

            unique case (state_q)
                StIdle: ;
                StArmed: begin
                    if (tick && trig_hit) begin
                        // Trigger sample is written to address 0 this cycle.
                        wr_ptr_q   <= CW'(1);
                        state_q    <= StCapture;
                        trig_out_q <= 1'b1;
                        arm_led_q  <= 1'b1;
                        trig_led_q <= 1'b0;
                    end
                end
                StCapture: begin
                    if (tick) begin
                        wr_ptr_q <= wr_ptr_q + CW'(1);
                        if ((wr_ptr_q + CW'(1)) >= delay_n) begin
                            state_q   <= StReadout;
                            rd_ptr_q  <= '0;
                            rd_left_q <= readout_len;
                            grp_q     <= grp_first;
                        end
                    end
                end
                StReadout: begin
                    if (!q_smp) begin
                        state_q <= StIdle;
                    end
                end
            endcase

            // Any host byte pops one pending response byte.
            if (rx_valid && pending) begin
                tx_valid_q <= 1'b1;
                tx_byte_q  <= head_byte;
                if (q_id) begin
                    id_left_q <= id_left_q - 3'd1;
                end else if (grp_more) begin
                    grp_q <= grp_next;
                end else begin
                    grp_q     <= grp_first;
                    rd_ptr_q  <= rd_ptr_q + AW'(1);
                    rd_left_q <= rd_left_q - CW'(1);
                end
            end

            // Command decode; placed last so an abort overrides the updates above.
            if (rx_valid) begin
                if (cmd_cnt_q == 3'd0) begin
                    if (rx_byte[7]) begin
                        opcode_q  <= rx_byte;
                        cmd_cnt_q <= 3'd1;
                    end else begin
                        case (rx_byte)
                            8'h00: begin
                                state_q    <= StIdle;
                                id_left_q  <= 3'd0;
                                rd_left_q  <= '0;
                                wr_ptr_q   <= '0;
                                tick_cnt_q <= 24'd0;
                                trig_out_q <= 1'b0;
                                arm_led_q  <= 1'b1;
                                trig_led_q <= 1'b1;
                                if (!pending) begin
                                    tx_byte_q <= 8'd0;
                                end
                            end
                            8'h01: begin
                                if (state_q == StIdle) begin
                                    state_q    <= StArmed;
                                    tick_cnt_q <= 24'd0;
                                    wr_ptr_q   <= '0;
                                    arm_led_q  <= 1'b0;
                                end
                            end
                            8'h02: id_left_q <= 3'd4;
                            default: ;
                        endcase
                    end
                end else begin
                    case (cmd_cnt_q)
                        3'd1: cmd_data_q[7:0]   <= rx_byte;
                        3'd2: cmd_data_q[15:8]  <= rx_byte;
                        3'd3: cmd_data_q[23:16] <= rx_byte;
                        default: begin
                            case (opcode_q)
                                8'h80: divider_q <= cmd_word[23:0];
                                8'h81: rd_del_q  <= cmd_word;
                                8'h82: begin
                                    grp_dis_q <= cmd_word[5:2];
`ifdef SUMP_TESTMODE_EN
                                    test_mode_q <= cmd_word[11];
`endif
                                end
                                8'hC0: trig_mask_q  <= cmd_word;
                                8'hC1: trig_value_q <= cmd_word;
                                8'hC2: trig_en_q    <= cmd_word[27];
                                default: ;
                            endcase
                        end
                    endcase
                    cmd_cnt_q <= (cmd_cnt_q == 3'd4) ? 3'd0 : (cmd_cnt_q + 3'd1);
                end
            end
        end
    end

    assign tx_valid      = tx_valid_q;
    assign tx_byte       = tx_byte_q;
    assign dataReady     = pending;
    assign extTriggerOut = trig_out_q;
    assign armLEDnn      = arm_led_q;
    assign triggerLEDnn  = trig_led_q;

endmodule

// File: tb/tb_sump_capture_core.sv
// tb_sump_capture_core
// Self-checking bench for sump_capture_core. The probe bus follows
// extData = base + cycle*step, so each returned sample is predicted from the
// ARM cycle, the divider and the group flags. Define SUMP_TESTMODE_EN to also
// exercise the counter sample source.

module tb_sump_capture_core;

    localparam int MEM_DEPTH = 64;

    logic        bf_clock = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        dataReady;
    logic [31:0] extData;
    logic        extTriggerIn;
    logic        extTriggerOut;
    logic        armLEDnn;
    logic        triggerLEDnn;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          edge_cyc = 0;
    logic [31:0] ext_base = 32'd0;
    logic [31:0] ext_step = 32'd0;
    logic [7:0]  got_q [$];
    logic [7:0]  exp_q [$];

    sump_capture_core #(
        .MEM_DEPTH(MEM_DEPTH),
        .ID_WORD  (32'h534C4131)
    ) dut (
        .bf_clock     (bf_clock),
        .reset        (reset),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .tx_valid     (tx_valid),
        .tx_byte      (tx_byte),
        .dataReady    (dataReady),
        .extData      (extData),
        .extTriggerIn (extTriggerIn),
        .extTriggerOut(extTriggerOut),
        .armLEDnn     (armLEDnn),
        .triggerLEDnn (triggerLEDnn)
    );

    always #5 bf_clock = ~bf_clock;

    // Probe bus changes mid-cycle; value at a rising edge is base + cyc*step.
    always @(negedge bf_clock) begin
        cyc     = cyc + 1;
        extData = ext_base + 32'(cyc) * ext_step;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge bf_clock);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge bf_clock);
        edge_cyc = cyc;
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_long(input logic [7:0] op, input logic [31:0] v);
        send_byte(op);
        for (int k = 0; k < 4; k++) send_byte(v[8*k +: 8]);
    endtask

    task automatic configure(input logic [23:0] d, input logic [15:0] rv, input logic [15:0] dv,
                             input logic [3:0] dis, input logic trig_en,
                             input logic [31:0] mask, input logic [31:0] value, input logic tm);
        send_byte(8'h00);
        send_long(8'hC0, mask);
        send_long(8'hC1, value);
        send_long(8'hC2, {4'd0, trig_en, 27'd0});
        send_long(8'h80, {8'd0, d});
        send_long(8'h81, {dv, rv});
        send_long(8'h82, {20'd0, tm, 5'd0, dis, 2'd0});
    endtask

    task automatic wait_ready(input int limit);
        int n = 0;
        while (!dataReady && n < limit) begin
            tick_n(1);
            n++;
        end
        check_eq("ready_rise", dataReady, 1);
    endtask

    task automatic drain(input int limit);
        int guard = 0;
        got_q.delete();
        while (dataReady && guard < limit) begin
            send_byte(8'h7F);
            check_eq("pop_valid", tx_valid, 1);
            got_q.push_back(tx_byte);
            guard++;
        end
        check_eq("drain_end", dataReady, 0);
    endtask

    function automatic int model_count(input int v);
        int n = (v + 1) * 4;
        return (n > MEM_DEPTH) ? MEM_DEPTH : n;
    endfunction

    // Expected bytes for an immediate-trigger capture of the ramp probe bus.
    task automatic build_ramp(input int d, input int rv, input int dv, input logic [3:0] dis,
                              input int arm_c);
        int          n;
        logic [31:0] s;
        n = model_count(rv);
        if (model_count(dv) < n) n = model_count(dv);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            s = ext_base + 32'(arm_c + i * (d + 1)) * ext_step;
            for (int g = 0; g < 4; g++) begin
                if (!dis[g]) exp_q.push_back(s[8*g +: 8]);
            end
        end
    endtask

    task automatic compare_readout(input string tag);
        check_eq({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check_eq($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    // ARM with an always-matching trigger and check the fire timing.
    task automatic arm_immediate(output int arm_c);
        send_byte(8'h01);
        arm_c = edge_cyc;
        check_eq("arm_led_on", armLEDnn, 0);
        check_eq("trig_out_early", extTriggerOut, 0);
        tick_n(1);
        check_eq("trig_out_pulse", extTriggerOut, 1);
        check_eq("arm_led_off", armLEDnn, 1);
        check_eq("trig_led_on", triggerLEDnn, 0);
        tick_n(1);
        check_eq("trig_out_end", extTriggerOut, 0);
    endtask

    task automatic run_ramp(input string tag, input int d, input int rv, input int dv,
                            input logic [3:0] dis, input logic [31:0] base,
                            input logic [31:0] step);
        int arm_c;
        int seen;
        configure(24'(d), 16'(rv), 16'(dv), dis, 1'b1, 32'd0, 32'd0, 1'b0);
        ext_base = base;
        ext_step = step;
        arm_immediate(arm_c);
        if (dis == 4'hF) begin
            seen = 0;
            repeat (300) begin
                tick_n(1);
                if (dataReady) seen = 1;
            end
            check_eq({tag, "_no_data"}, seen, 0);
        end else begin
            wait_ready(2000);
            drain(300);
            build_ramp(d, rv, dv, dis, arm_c);
            compare_readout(tag);
        end
    endtask

    initial begin
        int arm_c;
        int seen;
        int n;
        reset        = 1'b1;
        rx_valid     = 1'b0;
        rx_byte      = 8'd0;
        extTriggerIn = 1'b0;
        extData      = 32'd0;
        tick_n(3);
        reset = 1'b0;
        tick_n(1);

        check_eq("rst_tx_valid", tx_valid, 0);
        check_eq("rst_tx_byte", tx_byte, 0);
        check_eq("rst_ready", dataReady, 0);
        check_eq("rst_trig_out", extTriggerOut, 0);
        check_eq("rst_arm_led", armLEDnn, 1);
        check_eq("rst_trig_led", triggerLEDnn, 1);

        // Pop with nothing queued produces no byte.
        send_byte(8'h7F);
        check_eq("empty_pop", tx_valid, 0);

        // ID query
        send_byte(8'h02);
        check_eq("id_ready", dataReady, 1);
        send_byte(8'h7F); check_eq("id_b0", tx_byte, 8'h31);
        send_byte(8'h7F); check_eq("id_b1", tx_byte, 8'h41);
        send_byte(8'h7F); check_eq("id_b2", tx_byte, 8'h4C);
        send_byte(8'h7F); check_eq("id_b3", tx_byte, 8'h53);
        check_eq("id_valid", tx_valid, 1);
        check_eq("id_done", dataReady, 0);

        // Masked value match on the low byte: 20 samples, group 0 only.
        ext_base = 32'h0000_0011;
        ext_step = 32'd0;
        configure(24'd0, 16'd4, 16'd4, 4'hE, 1'b1, 32'h0000_00FF, 32'h0000_0040, 1'b0);
        send_byte(8'h01);
        tick_n(10);
        check_eq("match_armed", armLEDnn, 0);
        check_eq("match_not_yet", triggerLEDnn, 1);
        ext_base = 32'h0000_0040;
        n = 0;
        while (!extTriggerOut && n < 20) begin
            tick_n(1);
            n++;
        end
        check_eq("match_pulse", extTriggerOut, 1);
        check_eq("match_trig_led", triggerLEDnn, 0);
        check_eq("match_arm_led", armLEDnn, 1);
        wait_ready(200);
        drain(100);
        exp_q.delete();
        repeat (20) exp_q.push_back(8'h40);
        compare_readout("match");

        // External trigger input, then a 0x00 mid-readout pops and flushes.
        ext_base = 32'h0000_005A;
        configure(24'd0, 16'd0, 16'd0, 4'hE, 1'b0, 32'd0, 32'd0, 1'b0);
        send_byte(8'h01);
        tick_n(5);
        check_eq("ext_idle_trig", triggerLEDnn, 1);
        extTriggerIn = 1'b1;
        n = 0;
        while (!extTriggerOut && n < 10) begin
            tick_n(1);
            n++;
        end
        check_eq("ext_trig_pulse", extTriggerOut, 1);
        extTriggerIn = 1'b0;
        wait_ready(100);
        send_byte(8'h00);
        check_eq("flush_pop", tx_valid, 1);
        check_eq("flush_byte", tx_byte, 8'h5A);
        check_eq("flush_ready", dataReady, 0);
        tick_n(3);
        check_eq("flush_stays", dataReady, 0);

        // Divider 2, ramp by 1: consecutive samples differ by 3.
        run_ramp("div2", 2, 1, 1, 4'hE, 32'h0000_0000, 32'd1);
        for (int i = 1; i < got_q.size(); i++) begin
            check_eq("div2_step", 8'(got_q[i] - got_q[i-1]), 8'd3);
        end

        // Groups 0 and 2 enabled.
        run_ramp("grp02", 1, 0, 0, 4'hA, 32'h1122_3344, 32'h0103_0507);

        // 0x00 bytes inside the 0x81 payload are data: read 4, delay 16.
        run_ramp("zero_payload", 0, 0, 3, 4'h0, 32'hA5A5_0000, 32'h0101_0101);

        // Abort during capture, then re-arm with the kept configuration.
        configure(24'd3, 16'hFFFF, 16'hFFFF, 4'h0, 1'b1, 32'd0, 32'd0, 1'b0);
        ext_base = 32'hDEAD_0000;
        ext_step = 32'h0001_0203;
        arm_immediate(arm_c);
        tick_n(20);
        check_eq("abort_capturing", triggerLEDnn, 0);
        send_byte(8'h00);
        check_eq("abort_ready", dataReady, 0);
        check_eq("abort_arm_led", armLEDnn, 1);
        check_eq("abort_trig_led", triggerLEDnn, 1);
        check_eq("abort_trig_out", extTriggerOut, 0);
        check_eq("abort_tx_valid", tx_valid, 0);
        check_eq("abort_tx_byte", tx_byte, 0);
        seen = 0;
        repeat (300) begin
            tick_n(1);
            if (dataReady) seen = 1;
        end
        check_eq("abort_no_data", seen, 0);
        arm_immediate(arm_c);
        wait_ready(2000);
        drain(300);
        build_ramp(3, 16'hFFFF, 16'hFFFF, 4'h0, arm_c);
        compare_readout("rearm");

        // All groups disabled: nothing is queued.
        run_ramp("nogrp", 0, 0, 0, 4'hF, 32'd0, 32'd1);

        // Randomized captures.
        for (int t = 0; t < 8; t++) begin
            int rv;
            int dv;
            rv = ($urandom_range(0, 3) == 0) ? 16'hFFFF : $urandom_range(0, 4);
            dv = ($urandom_range(0, 3) == 0) ? 16'hFFFF : $urandom_range(0, 4);
            run_ramp($sformatf("rnd%0d", t), $urandom_range(0, 3), rv, dv,
                     4'($urandom_range(0, 14)), $urandom, $urandom);
        end

`ifdef SUMP_TESTMODE_EN
        // Counter source, divider 0: bytes step by one.
        configure(24'd0, 16'd1, 16'd1, 4'hE, 1'b1, 32'd0, 32'd0, 1'b1);
        arm_immediate(arm_c);
        wait_ready(200);
        drain(100);
        check_eq("tm_len", got_q.size(), 8);
        for (int i = 1; i < got_q.size(); i++) begin
            check_eq("tm_step", 8'(got_q[i] - got_q[i-1]), 8'd1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
